// File: rtl/overlay_pkg.sv
// Shared types and constants for the elapsed-seconds overlay: controller states,
// glyph geometry, null colour and the BCD digit type.
package overlay_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } ovl_state_t;

    typedef logic [3:0] bcd_t;

    localparam int          GLYPH_COLS = 28;
    localparam int          GLYPH_ROWS = 8;
    localparam logic [11:0] COLOR_NULL = 12'h000;

endpackage

// File: rtl/bcd3_counter.sv
// Three-digit BCD up-counter (000..999) with synchronous clear, saturate-hold
// and a decimal carry chain; at_max flags 999.
module bcd3_counter
    import overlay_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    input  logic i_sat,
    output bcd_t o_d0,
    output bcd_t o_d1,
    output bcd_t o_d2,
    output logic o_at_max
);

    bcd_t r_d0, r_d1, r_d2;
    logic w_at_max;

    assign w_at_max = (r_d0 == 4'd9) && (r_d1 == 4'd9) && (r_d2 == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
        end else if (i_clear) begin
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
        end else if (i_sat) begin
            r_d0 <= 4'd9;
            r_d1 <= 4'd9;
            r_d2 <= 4'd9;
        end else if (i_inc && !w_at_max) begin
            // Hundreds never see 9->0 because increments stop at 999.
            if (r_d0 == 4'd9) begin
                r_d0 <= '0;
                if (r_d1 == 4'd9) begin
                    r_d1 <= '0;
                    r_d2 <= r_d2 + 4'd1;
                end else begin
                    r_d1 <= r_d1 + 4'd1;
                end
            end else begin
                r_d0 <= r_d0 + 4'd1;
            end
        end
    end

    assign o_d0     = r_d0;
    assign o_d1     = r_d1;
    assign o_d2     = r_d2;
    assign o_at_max = w_at_max;

endmodule

// File: rtl/timer_overlay_ctrl.sv
// Elapsed-seconds overlay controller: run/pause/clear/saturate seconds counter,
// frame-synchronous digit shadow, and raster-to-glyph address pipeline.
module timer_overlay_ctrl
    import overlay_pkg::*;
#(
    parameter int          X0         = 16,
    parameter int          Y0         = 16,
    parameter int          SCALE_LOG2 = 1,
    parameter int unsigned TICK_DIV   = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        frame_start,
    input  logic        run,
    input  logic        clear,
    input  logic [11:0] rom_color,
    output logic [5:0]  rom_x,
    output logic [2:0]  rom_y,
    output logic [3:0]  a0,
    output logic [3:0]  a1,
    output logic [3:0]  a2,
    output logic [11:0] pixel_color,
    output logic        overlay_hit,
    output logic        saturated
);

    localparam int          PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [9:0]  WIN_W   = 10'(GLYPH_COLS << SCALE_LOG2);
    localparam logic [9:0]  WIN_H   = 10'(GLYPH_ROWS << SCALE_LOG2);

    ovl_state_t       r_state, w_state_nxt;
    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic             w_at_max;
    bcd_t             w_d0, w_d1, w_d2;
    bcd_t             r_a0, r_a1, r_a2;

    logic [10:0]      w_rel_x, w_rel_y;
    logic             w_in_win;
    logic [5:0]       r_rom_x;
    logic [2:0]       r_rom_y;
    logic             r_hit0, r_hit1, r_hit2;
    logic [11:0]      r_pix;
    logic             r_hit_out;

    assign w_tick = (r_state == RUN) && (r_pre == PRE_MAX) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (run) w_state_nxt = RUN;
                RUN: begin
                    if (w_tick && w_at_max) w_state_nxt = SAT;
                    else if (!run)          w_state_nxt = IDLE;
                end
                SAT:     w_state_nxt = SAT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Prescaler only advances in RUN, so a pause keeps the partial second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (clear) begin
            r_pre <= '0;
        end else if (r_state == RUN) begin
            r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + PRE_W'(1);
        end
    end

    bcd3_counter u_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (clear),
        .i_inc    (w_tick),
        .i_sat    (r_state == SAT),
        .o_d0     (w_d0),
        .o_d1     (w_d1),
        .o_d2     (w_d2),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0 <= '0;
            r_a1 <= '0;
            r_a2 <= '0;
        end else if (frame_start) begin
            r_a0 <= w_d0;
            r_a1 <= w_d1;
            r_a2 <= w_d2;
        end
    end

    // Two's-complement subtraction: bit 10 set means left of / above the window.
    assign w_rel_x  = {1'b0, h_cnt} - 11'(X0);
    assign w_rel_y  = {1'b0, v_cnt} - 11'(Y0);
    assign w_in_win = !w_rel_x[10] && (w_rel_x[9:0] < WIN_W) &&
                      !w_rel_y[10] && (w_rel_y[9:0] < WIN_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_x   <= '0;
            r_rom_y   <= '0;
            r_hit0    <= 1'b0;
            r_hit1    <= 1'b0;
            r_hit2    <= 1'b0;
            r_pix     <= COLOR_NULL;
            r_hit_out <= 1'b0;
        end else begin
            r_rom_x   <= w_in_win ? 6'(w_rel_x[9:0] >> SCALE_LOG2) : '0;
            r_rom_y   <= w_in_win ? 3'(w_rel_y[9:0] >> SCALE_LOG2) : '0;
            r_hit0    <= w_in_win;
            r_hit1    <= r_hit0;
            r_hit2    <= r_hit1;
            r_pix     <= r_hit2 ? rom_color : COLOR_NULL;
            r_hit_out <= r_hit2;
        end
    end

    assign rom_x       = r_rom_x;
    assign rom_y       = r_rom_y;
    assign a0          = r_a0;
    assign a1          = r_a1;
    assign a2          = r_a2;
    assign pixel_color = r_pix;
    assign overlay_hit = r_hit_out;
    assign saturated   = (r_state == SAT);

endmodule

// File: tb/tb_timer_overlay_ctrl.sv
// Directed bench for timer_overlay_ctrl with a 2-cycle glyph ROM model whose
// colour encodes {3'b101, rom_y, rom_x}.
module tb_timer_overlay_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        frame_start, run, clear;
    logic [11:0] rom_color = 12'h000;
    logic [5:0]  rom_x;
    logic [2:0]  rom_y;
    logic [3:0]  a0, a1, a2;
    logic [11:0] pixel_color;
    logic        overlay_hit, saturated;

    logic [8:0]  r_ra = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    timer_overlay_ctrl #(
        .X0         (16),
        .Y0         (16),
        .SCALE_LOG2 (1),
        .TICK_DIV   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .frame_start (frame_start),
        .run         (run),
        .clear       (clear),
        .rom_color   (rom_color),
        .rom_x       (rom_x),
        .rom_y       (rom_y),
        .a0          (a0),
        .a1          (a1),
        .a2          (a2),
        .pixel_color (pixel_color),
        .overlay_hit (overlay_hit),
        .saturated   (saturated)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_ra      <= {rom_y, rom_x};
        rom_color <= {3'b101, r_ra};
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_digits(input string tag, input logic [11:0] exp);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        check_val(tag, {4'h0, a2, a1, a0}, {4'h0, exp});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; h_cnt = '0; v_cnt = '0;
        frame_start = 1'b0; run = 1'b0; clear = 1'b0;
        cyc(2);
        check_val("rst_digits", {4'h0, a2, a1, a0}, 16'h0000);
        check_val("rst_rom_xy", {7'h0, rom_y, rom_x}, 16'h0000);
        check_val("rst_pixel", {4'h0, pixel_color}, 16'h0000);
        check_val("rst_hit_sat", {14'h0, overlay_hit, saturated}, 16'h0000);
        rst_n = 1'b1;

        // Count and pause: 40 cycles of run give ten ticks.
        run = 1'b1;
        cyc(40);
        run = 1'b0;
        cyc(10);
        read_digits("count_010", 12'h010);
        cyc(20);
        read_digits("pause_hold", 12'h010);
        check_val("pause_sat", {15'h0, saturated}, 16'h0000);

        // Shadow takes pre-increment value when frame_start meets the tick.
        run = 1'b1;
        cyc(128);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        run = 1'b0;
        check_val("shadow_041", {4'h0, a2, a1, a0}, 16'h0041);
        cyc(5);
        check_val("shadow_hold", {4'h0, a2, a1, a0}, 16'h0041);
        read_digits("live_042", 12'h042);

        // Clear beats the tick and run at 009.
        do_clear();
        run = 1'b1;
        cyc(40);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        run = 1'b0;
        read_digits("clear_prio", 12'h000);
        cyc(20);
        read_digits("clear_idle", 12'h000);

        // Carry chain through 998, 999, then saturate.
        run = 1'b1;
        cyc(3993);
        read_digits("count_998", 12'h998);
        check_val("sat_998", {15'h0, saturated}, 16'h0000);
        cyc(3);
        read_digits("count_999", 12'h999);
        cyc(2);
        check_val("sat_before", {15'h0, saturated}, 16'h0000);
        cyc(1);
        check_val("sat_set", {15'h0, saturated}, 16'h0001);
        cyc(80);
        read_digits("sat_hold", 12'h999);
        check_val("sat_still", {15'h0, saturated}, 16'h0001);
        do_clear();
        run = 1'b0;
        check_val("sat_cleared", {15'h0, saturated}, 16'h0000);
        read_digits("sat_clear_cnt", 12'h000);

        // Raster mapping and 3-cycle alignment.
        h_cnt = 10'd60; v_cnt = 10'd18;
        cyc(1);
        check_val("map_xy", {7'h0, rom_y, rom_x}, {7'h0, 3'd1, 6'd22});
        check_val("map_hit_t1", {15'h0, overlay_hit}, 16'h0000);
        h_cnt = 10'd72;
        cyc(1);
        check_val("edge72_xy", {7'h0, rom_y, rom_x}, 16'h0000);
        cyc(1);
        check_val("map_hit_t2", {3'h0, overlay_hit, pixel_color}, 16'h0000);
        cyc(1);
        check_val("map_hit_t3", {3'h0, overlay_hit, pixel_color}, {4'h1, 12'hA56});
        cyc(1);
        check_val("map_hit_t4", {3'h0, overlay_hit, pixel_color}, 16'h0000);
        h_cnt = 10'd71; v_cnt = 10'd31;
        cyc(1);
        check_val("last_col_row", {7'h0, rom_y, rom_x}, {7'h0, 3'd7, 6'd27});
        h_cnt = 10'd15;
        cyc(1);
        check_val("left_out", {7'h0, rom_y, rom_x}, 16'h0000);
        h_cnt = 10'd60; v_cnt = 10'd32;
        cyc(1);
        check_val("below_out", {7'h0, rom_y, rom_x}, 16'h0000);
        cyc(4);
        check_val("out_pixel", {3'h0, overlay_hit, pixel_color}, 16'h0000);

        // Async reset during RUN at 123 with the overlay showing.
        h_cnt = 10'd26; v_cnt = 10'd30;
        run = 1'b1;
        cyc(493);
        read_digits("count_123", 12'h123);
        check_val("pre_rst_pix", {3'h0, overlay_hit, pixel_color}, {4'h1, 12'hBC5});
        #2 rst_n = 1'b0;
        run = 1'b0;
        #1;
        check_val("arst_digits", {4'h0, a2, a1, a0}, 16'h0000);
        check_val("arst_rom_xy", {7'h0, rom_y, rom_x}, 16'h0000);
        check_val("arst_pixel", {3'h0, overlay_hit, pixel_color}, 16'h0000);
        check_val("arst_sat", {15'h0, saturated}, 16'h0000);
        #3 rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            check_val($sformatf("post_rst_%0d", i), {3'h0, overlay_hit, pixel_color}, 16'h0000);
        end
        cyc(1);
        check_val("post_rst_4", {3'h0, overlay_hit, pixel_color}, {4'h1, 12'hBC5});
        cyc(20);
        read_digits("post_rst_cnt", 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
